// File: rtl/boot_code_cpu.sv
// -----------------------------------------------------------------------------
// boot_code_cpu
//
// Boot-code interpreter core. It fetches 16-bit instructions from an external
// synchronous program ROM and executes nop/acc/jmp/halt. A visited bitmap
// records every executed address. The run stops on the first attempt to
// re-execute an address (looped=1), or when the program ends (looped=0). A
// program ends on halt or when the next pc falls outside 0..PROG_LEN-1. The
// accumulator is then latched onto value, and output_valid stays high until
// rst.
//
// Instruction word: [15:14] opcode (00 nop, 01 acc, 10 jmp, 11 halt),
//                   [13:0]  signed argument.
//
// Parameters:
//   ADDR_W       program address width; the bitmap holds 2^ADDR_W bits
//   PROG_LEN     number of valid instructions, 1..2^ADDR_W
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   enable       when low, all non-DONE state holds
//   instr_addr   registered ROM read address
//   instr_data   ROM word for the address driven in the previous cycle
//   output_valid sticky result-valid flag
//   value        accumulator snapshot at stop
//   looped       1 = stopped on repeat, 0 = terminated
//
// state | meaning
// ------+-----------------------------------------------------------------
// CLEAR | zero one visited bit per enabled cycle, 0..PROG_LEN-1
// FETCH | instr_addr already holds pc; read visited[pc]
// EXEC  | check visited bit, then execute the ROM word or stop
// DONE  | result latched; hold until rst (enable ignored)
// -----------------------------------------------------------------------------
module boot_code_cpu #(
    parameter int ADDR_W   = 10,
    parameter int PROG_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [15:0]       instr_data,
    output logic              output_valid,
    output logic [15:0]       value,
    output logic              looped
);

    typedef enum logic [1:0] {CLEAR, FETCH, EXEC, DONE} state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_ACC  = 2'b01;
    localparam logic [1:0] OP_JMP  = 2'b10;
    localparam logic [1:0] OP_HALT = 2'b11;

    localparam int DEPTH = 1 << ADDR_W;
    // Wide enough for pc + any 14-bit argument without overflow, plus sign.
    localparam int SUM_W = ((ADDR_W > 14) ? ADDR_W : 14) + 2;
    localparam logic [ADDR_W-1:0]       CLR_LAST = ADDR_W'(PROG_LEN - 1);
    localparam logic signed [SUM_W-1:0] LEN_S    = SUM_W'(PROG_LEN);

    state_t             state;
    logic [ADDR_W:0]    pc;
    logic [15:0]        acc;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [DEPTH-1:0]   visited;
    logic               vis_q;

    logic [1:0]              opcode;
    logic [15:0]             arg16;
    logic [15:0]             acc_exec;
    logic signed [SUM_W-1:0] arg_s;
    logic signed [SUM_W-1:0] pc_s;
    logic signed [SUM_W-1:0] npc_s;
    logic                    npc_out;

    logic                    vis_we;
    logic [ADDR_W-1:0]       vis_wa;
    logic                    vis_wd;

    always_comb begin
        opcode   = instr_data[15:14];
        arg16    = {{2{instr_data[13]}}, instr_data[13:0]};
        arg_s    = {{(SUM_W-14){instr_data[13]}}, instr_data[13:0]};
        pc_s     = {{(SUM_W-ADDR_W-1){1'b0}}, pc};
        npc_s    = (opcode == OP_JMP) ? pc_s + arg_s : pc_s + SUM_W'(1);
        npc_out  = npc_s[SUM_W-1] || (npc_s >= LEN_S);
        acc_exec = (opcode == OP_ACC) ? acc + arg16 : acc;
    end

    // Single write port: CLEAR zeroes clr_cnt, EXEC marks pc once it is
    // known not to be a repeat.
    always_comb begin
        vis_we = 1'b0;
        vis_wa = clr_cnt;
        vis_wd = 1'b0;
        if (!rst && enable) begin
            if (state == CLEAR) begin
                vis_we = 1'b1;
            end else if (state == EXEC && !vis_q) begin
                vis_we = 1'b1;
                vis_wa = pc[ADDR_W-1:0];
                vis_wd = 1'b1;
            end
        end
    end

    // Bitmap storage carries no reset; CLEAR rewrites every used bit.
    always_ff @(posedge clk) begin
        if (vis_we) begin
            visited[vis_wa] <= vis_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            pc           <= '0;
            acc          <= '0;
            clr_cnt      <= '0;
            vis_q        <= 1'b0;
            instr_addr   <= '0;
            output_valid <= 1'b0;
            value        <= '0;
            looped       <= 1'b0;
        end else if (enable && state != DONE) begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state      <= FETCH;
                        pc         <= '0;
                        acc        <= '0;
                        instr_addr <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                FETCH: begin
                    vis_q <= visited[pc[ADDR_W-1:0]];
                    state <= EXEC;
                end
                EXEC: begin
                    if (vis_q) begin
                        // Repeat detected before execution: acc untouched.
                        state        <= DONE;
                        output_valid <= 1'b1;
                        value        <= acc;
                        looped       <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_HALT: begin
                                state        <= DONE;
                                output_valid <= 1'b1;
                                value        <= acc;
                                looped       <= 1'b0;
                            end
                            OP_NOP, OP_ACC, OP_JMP: begin
                                acc <= acc_exec;
                                if (npc_out) begin
                                    state        <= DONE;
                                    output_valid <= 1'b1;
                                    value        <= acc_exec;
                                    looped       <= 1'b0;
                                end else begin
                                    // ROM address is set here, so the FETCH
                                    // cycle already presents the new pc.
                                    pc         <= npc_s[ADDR_W:0];
                                    instr_addr <= npc_s[ADDR_W-1:0];
                                    state      <= FETCH;
                                end
                            end
                        endcase
                    end
                end
                DONE: ;
            endcase
        end
    end

endmodule

// File: tb/tb_boot_code_cpu.sv
module tb_boot_code_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        enable;
    logic [3:0]  ia0, ia3;
    logic [0:0]  ia1, ia2;
    logic [15:0] d0, d1, d2, d3;
    logic [15:0] v0, v1, v2, v3;
    logic        ov0, ov1, ov2, ov3;
    logic        lp0, lp1, lp2, lp3;

    logic [15:0] rom [4][16];
    int          sel;

    logic        s_ov, s_lp;
    logic [15:0] s_val;
    logic [31:0] s_ia;

    int n_chk  = 0;
    int n_pass = 0;

    // dut 0: PROG_LEN=9, dut 1: PROG_LEN=2, dut 2: PROG_LEN=1, dut 3: random
    boot_code_cpu #(.ADDR_W(4), .PROG_LEN(9)) u0 (
        .clk(clk), .rst(rst), .enable(enable), .instr_addr(ia0),
        .instr_data(d0), .output_valid(ov0), .value(v0), .looped(lp0));
    boot_code_cpu #(.ADDR_W(1), .PROG_LEN(2)) u1 (
        .clk(clk), .rst(rst), .enable(enable), .instr_addr(ia1),
        .instr_data(d1), .output_valid(ov1), .value(v1), .looped(lp1));
    boot_code_cpu #(.ADDR_W(1), .PROG_LEN(1)) u2 (
        .clk(clk), .rst(rst), .enable(enable), .instr_addr(ia2),
        .instr_data(d2), .output_valid(ov2), .value(v2), .looped(lp2));
    boot_code_cpu #(.ADDR_W(4), .PROG_LEN(12)) u3 (
        .clk(clk), .rst(rst), .enable(enable), .instr_addr(ia3),
        .instr_data(d3), .output_valid(ov3), .value(v3), .looped(lp3));

    // Synchronous ROMs: address in cycle N, data in cycle N+1.
    always @(posedge clk) begin
        d0 <= rom[0][ia0];
        d1 <= rom[1][{3'b000, ia1}];
        d2 <= rom[2][{3'b000, ia2}];
        d3 <= rom[3][ia3];
    end

    always_comb begin
        case (sel)
            0:       begin s_ov = ov0; s_lp = lp0; s_val = v0; s_ia = {28'd0, ia0}; end
            1:       begin s_ov = ov1; s_lp = lp1; s_val = v1; s_ia = {31'd0, ia1}; end
            2:       begin s_ov = ov2; s_lp = lp2; s_val = v2; s_ia = {31'd0, ia2}; end
            default: begin s_ov = ov3; s_lp = lp3; s_val = v3; s_ia = {28'd0, ia3}; end
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", nm, got, exp);
    endtask

    function automatic int sx14(input logic [15:0] w);
        int a;
        a = int'(w[13:0]);
        if (w[13]) a -= 16384;
        return a;
    endfunction

    // Reference interpreter: walks the program with an int pc and a bit array.
    task automatic model(input int s, input int len, output logic [15:0] ev,
                         output logic el, output int ecyc);
        bit          vis [16];
        int          pc, acc, k, npc;
        logic [15:0] w;
        pc = 0; acc = 0; k = 0;
        ev = 16'h0; el = 1'b0; ecyc = 0;
        for (int i = 0; i < 16; i++) vis[i] = 1'b0;
        for (int step = 0; step <= len; step++) begin
            w = rom[s][pc];
            if (vis[pc]) begin el = 1'b1; ecyc = len + 2*k + 2; break; end
            vis[pc] = 1'b1;
            k++;
            if (w[15:14] == 2'b11) begin el = 1'b0; ecyc = len + 2*k; break; end
            if (w[15:14] == 2'b01) acc += sx14(w);
            npc = (w[15:14] == 2'b10) ? pc + sx14(w) : pc + 1;
            if (npc < 0 || npc >= len) begin el = 1'b0; ecyc = len + 2*k; break; end
            pc = npc;
        end
        ev = acc[15:0];
    endtask

    // Reset, release, and count cycles until output_valid; cyc is the cycle
    // index (cycle 0 = first cycle out of reset) in which valid is first seen.
    task automatic run(input int s, input int stall_pct, output int cyc, output int lows);
        sel = s; cyc = 0; lows = 0;
        @(negedge clk); rst = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        while (1) begin
            @(posedge clk); #1; cyc++;
            if (s_ov) break;
            if (cyc >= 600) begin chk("run_timeout", 32'd0, 32'd1); break; end
            @(negedge clk);
            if (int'($urandom_range(99)) < stall_pct) begin enable = 1'b0; lows++; end
            else enable = 1'b1;
        end
        enable = 1'b1;
    endtask

    typedef struct {
        int          sel;
        int          len;
        logic [15:0] exp_val;
        logic        exp_lp;
        int          exp_cyc;
    } vec_t;

    vec_t        tbl [6];
    logic [15:0] tprog [6][16];
    logic [15:0] loop_p [9] = '{16'h0000, 16'h4001, 16'h8004, 16'h4003, 16'hBFFD,
                                16'h7F9D, 16'h4001, 16'hBFFC, 16'h4006};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          cyc, lows, ecyc, r, j;
        logic [15:0] ev, w;
        logic        el, early, bad;

        rst = 1'b1; enable = 1'b1; sel = 0;
        for (int s = 0; s < 4; s++)
            for (int a = 0; a < 16; a++) rom[s][a] = 16'hC000;

        repeat (2) @(posedge clk); #1;
        chk("rst_valid", {28'd0, ov0, ov1, ov2, ov3}, 32'd0);
        chk("rst_value01", {v0, v1}, 32'd0);
        chk("rst_value23", {v2, v3}, 32'd0);
        chk("rst_looped", {28'd0, lp0, lp1, lp2, lp3}, 32'd0);
        chk("rst_addr", {22'd0, ia0, ia1, ia2, ia3}, 32'd0);

        // Directed table
        for (int v = 0; v < 6; v++)
            for (int a = 0; a < 16; a++) tprog[v][a] = 16'hC000;
        for (int a = 0; a < 9; a++) begin
            tprog[0][a] = loop_p[a];
            tprog[1][a] = loop_p[a];
        end
        tprog[1][7] = 16'h0000;
        tprog[2][0] = 16'h5FFF; tprog[2][1] = 16'hBFFF;
        tprog[3][0] = 16'h7FFF;
        tprog[4][0] = 16'hBFFF;
        tprog[5][0] = 16'h4002; tprog[5][1] = 16'h4002; tprog[5][2] = 16'h4002;
        tprog[5][3] = 16'hC000;

        tbl[0] = '{0, 9, 16'd5,    1'b1, 25};
        tbl[1] = '{0, 9, 16'd8,    1'b0, 21};
        tbl[2] = '{1, 2, 16'h1FFF, 1'b1, 8};
        tbl[3] = '{2, 1, 16'hFFFF, 1'b0, 3};
        tbl[4] = '{0, 9, 16'd0,    1'b0, 11};
        tbl[5] = '{0, 9, 16'd6,    1'b0, 17};

        for (int v = 0; v < 6; v++) begin
            for (int a = 0; a < 16; a++) rom[tbl[v].sel][a] = tprog[v][a];
            run(tbl[v].sel, 0, cyc, lows);
            chk($sformatf("vec%0d_value", v), s_val, tbl[v].exp_val);
            chk($sformatf("vec%0d_looped", v), s_lp, tbl[v].exp_lp);
            chk($sformatf("vec%0d_cycle", v), cyc, tbl[v].exp_cyc);
            @(negedge clk); enable = 1'b0;
            repeat (3) @(posedge clk); #1;
            chk($sformatf("vec%0d_sticky_valid", v), s_ov, 1'b1);
            chk($sformatf("vec%0d_sticky_value", v), s_val, tbl[v].exp_val);
            enable = 1'b1;
        end

        // Random enable stalls on the loop-detection program
        for (int a = 0; a < 16; a++) rom[0][a] = tprog[0][a];
        for (int t = 0; t < 4; t++) begin
            run(0, 30, cyc, lows);
            chk($sformatf("stall%0d_value", t), s_val, 16'd5);
            chk($sformatf("stall%0d_looped", t), s_lp, 1'b1);
            chk($sformatf("stall%0d_cycle", t), cyc, 25 + lows);
        end

        // Reset during EXEC of instruction 4 (cycle 18), then a clean rerun
        sel = 0;
        @(negedge clk); rst = 1'b1; enable = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0; early = 1'b0;
        while (cyc < 18) begin
            @(posedge clk); #1; cyc++;
            if (s_ov) early = 1'b1;
        end
        chk("mid_no_early_valid", early, 1'b0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", s_ov, 1'b0);
        chk("mid_rst_value", s_val, 16'd0);
        chk("mid_rst_addr", s_ia, 32'd0);
        @(negedge clk); rst = 1'b0;
        cyc = 0; bad = 1'b0;
        while (1) begin
            @(posedge clk); #1; cyc++;
            if (s_ov) break;
            if (s_val !== 16'd0 || s_lp !== 1'b0) bad = 1'b1;
            if (cyc >= 600) begin chk("mid_timeout", 32'd0, 32'd1); break; end
        end
        chk("mid_outputs_zero", bad, 1'b0);
        chk("mid_cycle", cyc, 25);
        chk("mid_value", s_val, 16'd5);
        chk("mid_looped", s_lp, 1'b1);

        // Random programs with random stalls against the reference model
        for (int t = 0; t < 25; t++) begin
            for (int a = 0; a < 16; a++) rom[3][a] = 16'hC000;
            for (int a = 0; a < 12; a++) begin
                r = int'($urandom_range(99));
                if (r < 20)      w = {2'b00, 14'($urandom)};
                else if (r < 55) w = {2'b01, 14'($urandom)};
                else if (r < 93) begin
                    j = int'($urandom_range(10)) - 5;
                    w = {2'b10, 14'(j)};
                end
                else             w = 16'hC000;
                rom[3][a] = w;
            end
            model(3, 12, ev, el, ecyc);
            run(3, 20, cyc, lows);
            chk($sformatf("rnd%0d_value", t), s_val, ev);
            chk($sformatf("rnd%0d_looped", t), s_lp, el);
            chk($sformatf("rnd%0d_cycle", t), cyc, ecyc + lows);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
